// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the basic-gate self-checker and its golden model.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions of each gate output within the 7-bit observation bus
  localparam int OBS_NOT  = 0;
  localparam int OBS_AND  = 1;
  localparam int OBS_OR   = 2;
  localparam int OBS_NAND = 3;
  localparam int OBS_NOR  = 4;
  localparam int OBS_XOR  = 5;
  localparam int OBS_XNOR = 6;
  localparam int OBS_W    = 7;

  localparam int NUM_VEC  = 4;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference for the two-input gate block: (a,b) -> expected 7-bit outputs.
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [OBS_W-1:0] expected
);

  always_comb begin
    expected           = '0;
    expected[OBS_NOT]  = ~a;
    expected[OBS_AND]  = a & b;
    expected[OBS_OR]   = a | b;
    expected[OBS_NAND] = ~(a & b);
    expected[OBS_NOR]  = ~(a | b);
    expected[OBS_XOR]  = a ^ b;
    expected[OBS_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_checker.sv
// Drives the four (a,b) vectors into the gate block, holds each for HOLD_CYCLES,
// and checks the sampled outputs against gate_golden to give a pass/fail verdict.
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 100,
  parameter int ERR_W       = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [OBS_W-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [OBS_W-1:0] err_mask,
  output logic [1:0]       first_fail_vec,
  output logic             fail_valid
);

  localparam int             CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]     LAST_VEC   = 2'(NUM_VEC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [OBS_W-1:0] gold;
  logic [OBS_W-1:0] mismatch;
  logic             launch;
  logic             sample;
  logic             last;
  logic             fail;
  logic [ERR_W-1:0] err_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // The registered stimulus itself feeds the reference, so gold always matches what obs should show
  gate_golden u_golden (
    .a        (a),
    .b        (b),
    .expected (gold)
  );

  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign sample   = (state == RUN) && (cnt == '0);
  assign last     = sample && (vec == LAST_VEC);
  assign mismatch = obs ^ gold;
  assign fail     = |mismatch;

  always_comb begin
    err_nxt = err_count;
    if (sample && fail && (err_count != '1)) begin
      err_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      err_mask       <= '0;
      first_fail_vec <= '0;
      fail_valid     <= 1'b0;
    end else if (launch) begin
      vec            <= '0;
      cnt            <= CNT_RELOAD;
      a              <= 1'b0;
      b              <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      err_mask       <= '0;
      first_fail_vec <= '0;
      fail_valid     <= 1'b0;
    end else if (state == RUN) begin
      if (sample) begin
        err_count <= err_nxt;
        err_mask  <= err_mask | mismatch;
        if (fail && !fail_valid) begin
          first_fail_vec <= vec;
          fail_valid     <= 1'b1;
        end
        // On the last vector {a,b} stays at 11 into DONE
        if (vec != LAST_VEC) begin
          vec    <= vec + 2'd1;
          cnt    <= CNT_RELOAD;
          {a, b} <= vec + 2'd1;
        end else begin
          pass <= (err_nxt == '0);
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: a HOLD_CYCLES=4 instance and a HOLD_CYCLES=1/ERR_W=1 instance.
module tb_gate_checker;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] errCount;
    logic [6:0] errMask;
    logic [1:0] firstFail;
    logic       failValid;
  } dut_out_t;

  typedef struct {
    logic [7:0] errCount;
    logic [6:0] errMask;
    logic [1:0] firstFail;
    logic       failValid;
    logic       pass;
  } result_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [6:0] stuck0 = '0;
  logic [6:0] stuck1 = '0;
  logic [6:0] obs0, obs1;

  logic       a0, b0, busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [6:0] mask0;
  logic [1:0] ff0;
  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [0:0] err1;
  logic [6:0] mask1;
  logic [1:0] ff1;

  logic       ga, gb;
  logic [6:0] gexp;

  dut_out_t   out0, out1;
  int         testsRun    = 0;
  int         testsFailed = 0;
  result_t    expQ[$];
  logic [1:0] vecQ[$];

  always #5 clk = ~clk;

  // Truth table written out bit-for-bit, independent of the gate equations
  function automatic logic [6:0] goldenRef(input logic [1:0] v);
    case (v)
      2'b00:   return 7'b1011001;
      2'b01:   return 7'b0101101;
      2'b10:   return 7'b0101100;
      default: return 7'b1000110;
    endcase
  endfunction

  assign obs0 = goldenRef({a0, b0}) & ~stuck0;
  assign obs1 = goldenRef({a1, b1}) & ~stuck1;
  assign out0 = {a0, b0, busy0, done0, pass0, err0, mask0, ff0, fv0};
  assign out1 = {a1, b1, busy1, done1, pass1, 7'b0, err1, mask1, ff1, fv1};

  gate_checker #(.HOLD_CYCLES(4), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .obs(obs0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .err_mask(mask0),
    .first_fail_vec(ff0), .fail_valid(fv0)
  );

  gate_checker #(.HOLD_CYCLES(1), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .obs(obs1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .err_mask(mask1),
    .first_fail_vec(ff1), .fail_valid(fv1)
  );

  gate_golden u_ref (.a(ga), .b(gb), .expected(gexp));

  function automatic result_t expectRun(input logic [6:0] stuck, input int errW);
    result_t    r;
    logic [6:0] g;
    logic [6:0] mis;
    int         maxv = (1 << errW) - 1;
    int         cnt  = 0;
    r.errMask   = '0;
    r.firstFail = '0;
    r.failValid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      g   = goldenRef(2'(v));
      mis = g ^ (g & ~stuck);
      if (mis != '0) begin
        if (cnt < maxv) cnt++;
        r.errMask = r.errMask | mis;
        if (!r.failValid) begin
          r.firstFail = 2'(v);
          r.failValid = 1'b1;
        end
      end
    end
    r.errCount = 8'(cnt);
    r.pass     = (cnt == 0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one run on the selected instance and checks every cycle of it plus the final verdict
  task automatic applyStimulus(input int sel, input logic [6:0] stuck, input bit holdStart);
    dut_out_t o;
    result_t  r;
    int       hold = (sel != 0) ? 1 : 4;
    int       w    = (sel != 0) ? 1 : 8;
    if (sel != 0) stuck1 = stuck; else stuck0 = stuck;
    expQ.push_back(expectRun(stuck, w));
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < hold; h++) vecQ.push_back(2'(v));
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    if (!holdStart) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    for (int c = 0; c < 4 * hold; c++) begin
      o = (sel != 0) ? out1 : out0;
      checkOutput("busy_run", 32'(o.busy), 32'd1);
      checkOutput("done_run", 32'(o.done), 32'd0);
      if (vecQ.size() == 0) checkOutput("vecq_underflow", 32'd0, 32'd1);
      else checkOutput($sformatf("vec_c%0d", c), 32'({o.a, o.b}), 32'(vecQ.pop_front()));
      @(negedge clk);
    end
    o = (sel != 0) ? out1 : out0;
    checkOutput("busy_end", 32'(o.busy), 32'd0);
    checkOutput("done_end", 32'(o.done), 32'd1);
    checkOutput("ab_end", 32'({o.a, o.b}), 32'd3);
    if (expQ.size() == 0) begin
      checkOutput("expq_underflow", 32'd0, 32'd1);
    end else begin
      r = expQ.pop_front();
      checkOutput("err_count", 32'(o.errCount), 32'(r.errCount));
      checkOutput("err_mask", 32'(o.errMask), 32'(r.errMask));
      checkOutput("first_fail_vec", 32'(o.firstFail), 32'(r.firstFail));
      checkOutput("fail_valid", 32'(o.failValid), 32'(r.failValid));
      checkOutput("pass", 32'(o.pass), 32'(r.pass));
    end
  endtask

  initial begin
    #3;
    checkOutput("reset_dut0", 32'(out0), 32'd0);
    checkOutput("reset_dut1", 32'(out1), 32'd0);

    for (int v = 0; v < 4; v++) begin
      {ga, gb} = 2'(v);
      #1;
      checkOutput($sformatf("golden_%0d", v), 32'(gexp), 32'(goldenRef(2'(v))));
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 7'b0000000, 1'b0);
    applyStimulus(0, 7'b0100000, 1'b0);

    // Reset in the middle of vector 2, checked before any clock edge
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_vec", 32'({a0, b0}), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset", 32'(out0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 7'b0100000, 1'b0);

    applyStimulus(0, 7'b0000000, 1'b1);
    @(negedge clk);
    checkOutput("restart_busy", 32'(busy0), 32'd1);
    checkOutput("restart_done", 32'(done0), 32'd0);
    checkOutput("restart_ab", 32'({a0, b0}), 32'd0);
    start0 = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;

    applyStimulus(1, 7'b1111111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
